// File: rtl/pwm_multichannel_buffered.sv
// pwm_multichannel_buffered
// N-channel PWM generator with a runtime period, a clock prescaler, and
// shadowed level/period registers. Shadow values are copied into the active
// registers at each period wrap, so an update never produces a runt pulse.
// Edge-aligned (sawtooth) and center-aligned (triangle) counting are both
// supported. While the generator is disabled, the active registers follow the
// shadow registers, so the first period after enabling uses the latest values.
module pwm_multichannel_buffered #(
  parameter int NUM_CHANNELS   = 8,
  parameter int LEVEL_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int ADDR_WIDTH     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LEVEL_WIDTH-1:0]  wr_data,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic                    period_tick
);

  localparam logic [ADDR_WIDTH-1:0]     ADDR_PERIOD   = ADDR_WIDTH'(NUM_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_PRESCALE = ADDR_WIDTH'(NUM_CHANNELS + 1);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_CTRL     = ADDR_WIDTH'(NUM_CHANNELS + 2);
  localparam logic [LEVEL_WIDTH-1:0]    CNT_ONE       = LEVEL_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE       = PRESCALE_WIDTH'(1);

  // Global configuration and timebase state
  logic [LEVEL_WIDTH-1:0]    shadow_period_q, shadow_period_d;
  logic [LEVEL_WIDTH-1:0]    active_period_q, active_period_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      enable_q, enable_d;
  logic                      center_q, center_d;
  logic [LEVEL_WIDTH-1:0]    counter_q, counter_d;
  logic                      dir_down_q, dir_down_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                      period_tick_q, period_tick_d;
  logic [NUM_CHANNELS-1:0]   pwm_q, pwm_d;

  // Decoded strobes and timebase events
  logic wr_period;
  logic wr_prescale;
  logic wr_ctrl;
  logic tick;
  logic wrap;
  logic load_active;
  logic center_change;

  // Write decode for the global registers. Prescale and control take effect
  // immediately. The period is only staged in its shadow register.
  always_comb begin
    wr_period       = wr_en && (wr_addr == ADDR_PERIOD);
    wr_prescale     = wr_en && (wr_addr == ADDR_PRESCALE);
    wr_ctrl         = wr_en && (wr_addr == ADDR_CTRL);
    shadow_period_d = wr_period ? wr_data : shadow_period_q;
    prescale_d      = wr_prescale ? PRESCALE_WIDTH'(wr_data) : prescale_q;
    enable_d        = wr_ctrl ? wr_data[0] : enable_q;
    center_d        = wr_ctrl ? wr_data[1] : center_q;
    center_change   = (center_d != center_q);
  end

  // Prescaler and up/up-down counter. A wrap is the commit point for the shadows.
  always_comb begin
    counter_d  = counter_q;
    dir_down_d = dir_down_q;
    pre_cnt_d  = pre_cnt_q;
    wrap       = 1'b0;
    // '>=' rather than '==' so that lowering S below the running count
    // still produces a tick instead of stalling until the count wraps.
    tick       = (pre_cnt_q >= prescale_q);
    if (!enable_d || center_change) begin
      // Disabled, or the mode changed: park the timebase at the start of a
      // period without signalling a wrap.
      counter_d  = '0;
      dir_down_d = 1'b0;
      pre_cnt_d  = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      if (active_period_q == '0) begin
        counter_d  = '0;
        dir_down_d = 1'b0;
        wrap       = 1'b1;
      end else if (!center_q) begin
        if (counter_q >= active_period_q) begin
          counter_d = '0;
          wrap      = 1'b1;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end else if (!dir_down_q) begin
        if (counter_q >= active_period_q) begin
          counter_d  = active_period_q - CNT_ONE;
          dir_down_d = 1'b1;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end else begin
        // The bottom of the triangle is the period boundary. Zero is visited
        // exactly once per period, and counting resumes at 1.
        if (counter_q == '0) begin
          counter_d  = CNT_ONE;
          dir_down_d = 1'b0;
          wrap       = 1'b1;
        end else begin
          counter_d = counter_q - CNT_ONE;
        end
      end
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end
  end

  // Commit the shadows on a wrap, and follow them continuously while disabled
  // (either side of an enable write) so that enabling starts with fresh values.
  always_comb begin
    load_active     = wrap || !enable_q || !enable_d;
    active_period_d = load_active ? shadow_period_d : active_period_q;
    period_tick_d   = wrap;
  end

  // Global state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_period_q <= '1;
      active_period_q <= '1;
      prescale_q      <= '0;
      enable_q        <= 1'b0;
      center_q        <= 1'b0;
      counter_q       <= '0;
      dir_down_q      <= 1'b0;
      pre_cnt_q       <= '0;
      period_tick_q   <= 1'b0;
      pwm_q           <= '0;
    end else begin
      shadow_period_q <= shadow_period_d;
      active_period_q <= active_period_d;
      prescale_q      <= prescale_d;
      enable_q        <= enable_d;
      center_q        <= center_d;
      counter_q       <= counter_d;
      dir_down_q      <= dir_down_d;
      pre_cnt_q       <= pre_cnt_d;
      period_tick_q   <= period_tick_d;
      pwm_q           <= pwm_d;
    end
  end

  // Per-channel shadow/active level pair and compare
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [LEVEL_WIDTH-1:0] shadow_level_q, shadow_level_d;
      logic [LEVEL_WIDTH-1:0] active_level_q, active_level_d;
      logic                   wr_level;

      // Level write, with write-through into the active copy on a commit edge
      always_comb begin
        wr_level       = wr_en && (wr_addr == ADDR_WIDTH'(gi));
        shadow_level_d = wr_level ? wr_data : shadow_level_q;
        active_level_d = load_active ? shadow_level_d : active_level_q;
      end

      // The output compares the present counter with the present active level,
      // so pwm_out lags the counter by exactly one clock.
      assign pwm_d[gi] = enable_d && (counter_q < active_level_q);

      // Level registers with synchronous reset
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_level_q <= '0;
          active_level_q <= '0;
        end else begin
          shadow_level_q <= shadow_level_d;
          active_level_q <= active_level_d;
        end
      end
    end
  endgenerate

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multichannel_buffered.sv
// tb_pwm_multichannel_buffered
// Directed bench. Waveforms are captured as bit masks, one bit per clock
// (bit 0 = first sample after sync), and compared with hand-derived patterns.
module tb_pwm_multichannel_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] pwm_out;
  logic       period_tick;

  int total = 0;
  int bad   = 0;

  logic [31:0] bits;
  logic [31:0] tbits;
  logic [7:0]  acc;
  logic        tacc;

  pwm_multichannel_buffered #(
    .NUM_CHANNELS  (8),
    .LEVEL_WIDTH   (8),
    .PRESCALE_WIDTH(8),
    .ADDR_WIDTH    (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Compare an observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One register write, driven on the falling edge
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) for the next sampled period_tick
  task automatic sync_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 600);
    chk(tag, 32'(period_tick), 32'd1);
  endtask

  // Sample channel ch and period_tick for n clocks; optionally write wa<=wd
  // right after sample wk (taken on the following rising edge)
  task automatic capture(input int ch, input int n, input int wk,
                         input logic [4:0] wa, input logic [7:0] wd,
                         output logic [31:0] b, output logic [31:0] tb);
    b  = '0;
    tb = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      b[k]  = pwm_out[ch];
      tb[k] = period_tick;
      if (k == wk) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_tick", 32'(period_tick), 32'h0);
    reset = 1'b0;

    // Basic edge mode: ch0=3, P=7 -> 3 high of 8, tick every 8
    wr(5'd0, 8'd3);
    wr(5'd8, 8'd7);
    wr(5'd10, 8'd1);
    sync_tick("t1_sync");
    capture(0, 16, -1, 5'd0, 8'd0, bits, tbits);
    chk("t1_ch0", bits, 32'h0000_0707);
    chk("t1_tick", tbits, 32'h0000_8080);
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = acc | pwm_out;
    end
    chk("t1_others", 32'(acc[7:1]), 32'h0);

    // Mid-period update: ch1 2->6 written at counter=4, P=9
    wr(5'd1, 8'd2);
    wr(5'd8, 8'd9);
    sync_tick("t2_sync");
    capture(1, 30, 3, 5'd1, 8'd6, bits, tbits);
    chk("t2_ch1", bits, 32'h03F0_FC03);
    chk("t2_tick", tbits, 32'h2008_0200);

    // Prescale=3, P=3, ch2=2 -> 8 high / 8 low, tick every 16
    wr(5'd2, 8'd2);
    wr(5'd8, 8'd3);
    wr(5'd9, 8'd3);
    sync_tick("t3_sync");
    capture(2, 32, -1, 5'd0, 8'd0, bits, tbits);
    chk("t3_ch2", bits, 32'h00FF_00FF);
    chk("t3_tick", tbits, 32'h8000_8000);

    // Center mode, P=4, ch3=2 -> high at counts 0 and both 1s
    wr(5'd9, 8'd0);
    wr(5'd3, 8'd2);
    wr(5'd8, 8'd4);
    wr(5'd10, 8'd3);
    sync_tick("t4_sync");
    capture(3, 16, -1, 5'd0, 8'd0, bits, tbits);
    chk("t4_ch3", bits, 32'h0000_C1C1);
    chk("t4_tick", tbits, 32'h0000_8080);

    // P=0: ch5=1 constant high, tick every clock; ch4=0 always low
    wr(5'd10, 8'd1);
    wr(5'd8, 8'd0);
    wr(5'd5, 8'd1);
    sync_tick("t5_sync");
    capture(5, 16, -1, 5'd0, 8'd0, bits, tbits);
    chk("t5_ch5", bits, 32'h0000_FFFF);
    chk("t5_tick", tbits, 32'h0000_FFFF);
    capture(4, 16, -1, 5'd0, 8'd0, bits, tbits);
    chk("t5_ch4_zero", bits, 32'h0);

    // ch4=255 with P=254 -> always high, no tick inside the window
    wr(5'd4, 8'd255);
    wr(5'd8, 8'd254);
    sync_tick("t6_sync");
    capture(4, 32, -1, 5'd0, 8'd0, bits, tbits);
    chk("t6_ch4_full", bits, 32'hFFFF_FFFF);
    chk("t6_tick", tbits, 32'h0);

    // Write ch6=2 on the exact wrap edge -> active immediately
    wr(5'd8, 8'd3);
    sync_tick("t7_sync");
    capture(6, 12, 2, 5'd6, 8'd2, bits, tbits);
    chk("t7_ch6", bits, 32'h0000_0330);
    chk("t7_tick", tbits, 32'h0000_0888);

    // Disable mid-period -> outputs low on the next edge, no ticks
    sync_tick("t8_sync");
    @(negedge clk);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd10;
    wr_data = 8'd0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t8_pwm_off", 32'(pwm_out), 32'h0);
    acc  = '0;
    tacc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc  = acc | pwm_out;
      tacc = tacc | period_tick;
    end
    chk("t8_pwm_idle", 32'(acc), 32'h0);
    chk("t8_tick_idle", 32'(tacc), 32'h0);

    // Re-enable: the counter restarts at 0, so ch0 gives 1,1,1,0
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd10;
    wr_data = 8'd1;
    capture(0, 4, -1, 5'd0, 8'd0, bits, tbits);
    chk("t9_ch0", bits, 32'h7);
    chk("t9_tick", tbits, 32'h8);

    // Reset together with a write: the write is discarded
    @(negedge clk);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 8'd200;
    @(negedge clk);
    chk("t10_rst_pwm", 32'(pwm_out), 32'h0);
    chk("t10_rst_tick", 32'(period_tick), 32'h0);
    reset = 1'b0;
    wr_en = 1'b0;
    wr(5'd10, 8'd1);
    capture(0, 16, -1, 5'd0, 8'd0, bits, tbits);
    chk("t10_ch0_cleared", bits, 32'h0);
    chk("t10_tick", tbits, 32'h0);
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = acc | pwm_out;
    end
    chk("t10_all_levels_zero", 32'(acc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
